// File: rtl/sensor_input_conditioner.sv
// Board input front end: synchronizes, debounces and press-detects raw switches and buttons.
// Define BUTTON_AUTOREPEAT_EN to add hold-to-repeat pulses on the two push-buttons.
module sensor_input_conditioner #(
   parameter int SYNC_STAGES        = 2,
   parameter int TICK_DIV           = 50000,
   parameter int DEBOUNCE_TICKS     = 8,
   parameter int REPEAT_DELAY_TICKS = 64,
   parameter int REPEAT_RATE_TICKS  = 16
) (
   input  logic clock,
   input  logic reset_n,
   input  logic low_water_level_raw,
   input  logic mid_water_level_raw,
   input  logic high_water_level_raw,
   input  logic earth_humidity_raw,
   input  logic air_humidity_raw,
   input  logic low_temperature_raw,
   input  logic selector_raw,
   input  logic pulse_3_raw,
   input  logic pulse_2_raw,
   output logic low_water_level,
   output logic mid_water_level,
   output logic high_water_level,
   output logic earth_humidity,
   output logic air_humidity,
   output logic low_temperature,
   output logic selector,
   output logic pulse_3,
   output logic pulse_2,
   output logic sample_tick
);

   localparam int NCH  = 9;
   localparam int BTN0 = 7;
   localparam int CW   = $clog2(DEBOUNCE_TICKS + 1);
   localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   // Buttons are active-low at the pin; their lanes work in pressed=1 terms.
   localparam logic [NCH-1:0] ACT_LOW = 9'b110000000;

   logic [PW-1:0]                   presc;
   logic [NCH-1:0]                  raw_vec, synced, stable, commit;
   logic [NCH-1:0][SYNC_STAGES-1:0] sync_q;
   logic [NCH-1:0][CW-1:0]          cnt, cnt_inc;
   logic [1:0]                      rise, pulse_q;

   assign raw_vec = {pulse_2_raw, pulse_3_raw, selector_raw, low_temperature_raw,
                     air_humidity_raw, earth_humidity_raw, high_water_level_raw,
                     mid_water_level_raw, low_water_level_raw};

   assign sample_tick = (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge clock) begin
      if (!reset_n)         presc <= '0;
      else if (sample_tick) presc <= '0;
      else                  presc <= presc + PW'(1);
   end

   // commit marks the tick on which a lane's stable level flips.
   always_comb begin
      synced  = '0;
      cnt_inc = '0;
      commit  = '0;
      for (int i = 0; i < NCH; i++) begin
         synced[i]  = sync_q[i][SYNC_STAGES-1] ^ ACT_LOW[i];
         cnt_inc[i] = (cnt[i] == CW'(DEBOUNCE_TICKS)) ? cnt[i] : cnt[i] + CW'(1);
         commit[i]  = sample_tick && (synced[i] != stable[i]) &&
                      (cnt_inc[i] == CW'(DEBOUNCE_TICKS));
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < NCH; i++) sync_q[i] <= {SYNC_STAGES{ACT_LOW[i]}};
         stable <= '0;
         cnt    <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_vec[i]};
            if (sample_tick) begin
               if (commit[i]) begin
                  stable[i] <= synced[i];
                  cnt[i]    <= '0;
               end else if (synced[i] != stable[i]) begin
                  cnt[i] <= cnt_inc[i];
               end else begin
                  cnt[i] <= '0;
               end
            end
         end
      end
   end

   assign rise = commit[BTN0+1:BTN0] & ~stable[BTN0+1:BTN0];

`ifdef BUTTON_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS
                                                                  : REPEAT_RATE_TICKS;
   localparam int RW   = $clog2(RMAX + 1);

   logic [1:0]         fall, rep_on, rep_rate, rep_fire;
   logic [1:0][RW-1:0] rep_cnt, rep_inc;

   // A repeat due on the same tick the release commits is suppressed.
   always_comb begin
      fall     = '0;
      rep_inc  = '0;
      rep_fire = '0;
      for (int b = 0; b < 2; b++) begin
         fall[b]     = commit[BTN0+b] & stable[BTN0+b];
         rep_inc[b]  = rep_cnt[b] + RW'(1);
         rep_fire[b] = rep_on[b] && sample_tick && !fall[b] &&
                       (rep_inc[b] == (rep_rate[b] ? RW'(REPEAT_RATE_TICKS)
                                                   : RW'(REPEAT_DELAY_TICKS)));
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pulse_q  <= '0;
         rep_on   <= '0;
         rep_rate <= '0;
         rep_cnt  <= '0;
      end else begin
         pulse_q <= rise | rep_fire;
         for (int b = 0; b < 2; b++) begin
            if (rise[b]) begin
               rep_on[b]   <= 1'b1;
               rep_rate[b] <= 1'b0;
               rep_cnt[b]  <= '0;
            end else if (fall[b]) begin
               rep_on[b]  <= 1'b0;
               rep_cnt[b] <= '0;
            end else if (rep_on[b] && sample_tick) begin
               if (rep_fire[b]) begin
                  rep_cnt[b]  <= '0;
                  rep_rate[b] <= 1'b1;
               end else begin
                  rep_cnt[b] <= rep_inc[b];
               end
            end
         end
      end
   end
`else
   always_ff @(posedge clock) begin
      if (!reset_n) pulse_q <= '0;
      else          pulse_q <= rise;
   end
`endif

   assign low_water_level  = stable[0];
   assign mid_water_level  = stable[1];
   assign high_water_level = stable[2];
   assign earth_humidity   = stable[3];
   assign air_humidity     = stable[4];
   assign low_temperature  = stable[5];
   assign selector         = stable[6];
   assign pulse_3          = pulse_q[0];
   assign pulse_2          = pulse_q[1];

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Bench for sensor_input_conditioner: directed scenarios plus random input walks,
// every cycle compared against a tick-level behavioural model of the conditioning rules.
module tb_sensor_input_conditioner;

   localparam int SYNC = 2, TD = 4, DEB = 3, RD = 4, RR = 2;
   localparam logic [8:0] BTN_MASK = 9'b110000000;
`ifdef BUTTON_AUTOREPEAT_EN
   localparam logic REP_ON = 1'b1;
`else
   localparam logic REP_ON = 1'b0;
`endif

   logic       clock   = 1'b0;
   logic       reset_n = 1'b0;
   logic [8:0] drv     = '0;
   logic low_water_level, mid_water_level, high_water_level, earth_humidity;
   logic air_humidity, low_temperature, selector, pulse_3, pulse_2, sample_tick;

   int checks = 0, errors = 0, n = 0;
   logic [8:0] hist[$];
   logic [8:0] m_stable = '0;
   logic [1:0] m_pulse  = '0;
   int         m_cnt[9];
   int         press_k[2];
   string names[10] = '{"low_water_level", "mid_water_level", "high_water_level",
                        "earth_humidity", "air_humidity", "low_temperature", "selector",
                        "pulse_3", "pulse_2", "sample_tick"};

   always #5 clock = ~clock;

   sensor_input_conditioner #(
      .SYNC_STAGES(SYNC), .TICK_DIV(TD), .DEBOUNCE_TICKS(DEB),
      .REPEAT_DELAY_TICKS(RD), .REPEAT_RATE_TICKS(RR)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .low_water_level_raw(drv[0]), .mid_water_level_raw(drv[1]),
      .high_water_level_raw(drv[2]), .earth_humidity_raw(drv[3]),
      .air_humidity_raw(drv[4]), .low_temperature_raw(drv[5]),
      .selector_raw(drv[6]), .pulse_3_raw(drv[7]), .pulse_2_raw(drv[8]),
      .low_water_level(low_water_level), .mid_water_level(mid_water_level),
      .high_water_level(high_water_level), .earth_humidity(earth_humidity),
      .air_humidity(air_humidity), .low_temperature(low_temperature),
      .selector(selector), .pulse_3(pulse_3), .pulse_2(pulse_2),
      .sample_tick(sample_tick)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, n, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      n        = 0;
      m_stable = '0;
      m_pulse  = '0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      press_k[0] = 0;
      press_k[1] = 0;
   endtask

   // act: inputs in pressed/asserted=1 terms for the cycle just clocked.
   task automatic model_step(input logic [8:0] act);
      logic [8:0] sy;
      logic [1:0] was_pressed, fell;
      int k;
      sy = (n >= SYNC) ? hist[n-SYNC] : 9'b0;
      hist.push_back(act);
      m_pulse = '0;
      if ((n % TD) == TD - 1) begin
         k           = n / TD;
         was_pressed = m_stable[8:7];
         fell        = '0;
         for (int ch = 0; ch < 9; ch++) begin
            if (sy[ch] != m_stable[ch]) begin
               m_cnt[ch]++;
               if (m_cnt[ch] == DEB) begin
                  m_stable[ch] = sy[ch];
                  m_cnt[ch]    = 0;
                  if (ch >= 7) begin
                     if (sy[ch]) begin
                        m_pulse[ch-7] = 1'b1;
                        press_k[ch-7] = k;
                     end else begin
                        fell[ch-7] = 1'b1;
                     end
                  end
               end
            end else begin
               m_cnt[ch] = 0;
            end
         end
         for (int b = 0; b < 2; b++)
            if (REP_ON && was_pressed[b] && !fell[b] && (k - press_k[b]) >= RD &&
                ((k - press_k[b] - RD) % RR) == 0)
               m_pulse[b] = 1'b1;
      end
      n++;
   endtask

   task automatic check_all();
      logic [9:0] obs, exp;
      obs = {sample_tick, pulse_2, pulse_3, selector, low_temperature, air_humidity,
             earth_humidity, high_water_level, mid_water_level, low_water_level};
      exp = {((n % TD) == TD - 1), m_pulse, m_stable[6:0]};
      for (int i = 0; i < 10; i++) chk(names[i], obs[i], exp[i]);
   endtask

   // Entered and left at a falling edge; d is pin-level drive for this cycle.
   task automatic run_cycle(input logic [8:0] d, input logic rst);
      drv     = d;
      reset_n = rst;
      #1 check_all();
      @(posedge clock);
      if (!rst) model_reset();
      else      model_step(d ^ BTN_MASK);
      @(negedge clock);
   endtask

   initial begin
      logic [8:0] base, d;
      logic       rst;
      base = BTN_MASK;

      // Reset held with all levels asserted and both buttons pressed.
      drv = 9'b001111111;
      repeat (2) @(posedge clock);
      @(negedge clock);
      model_reset();
      for (int c = 0; c < 10; c++) run_cycle(9'b001111111, 1'b0);

      // Clean edge, short glitch, long press then release.
      for (int c = 0; c < 140; c++) begin
         d    = base;
         d[1] = 1'b1;
         d[4] = (c <= 5);
         d[8] = (c >= 100);
         if (c == 3 || c == 7) chk("tick_on", sample_tick, 1'b1);
         if (c == 4)  chk("tick_off", sample_tick, 1'b0);
         if (c == 11) chk("mid_before", mid_water_level, 1'b0);
         if (c == 12) chk("mid_after", mid_water_level, 1'b1);
         if (c == 12) chk("press_pulse", pulse_2, 1'b1);
         if (c == 13) chk("press_once", pulse_2, 1'b0);
         if (c == 20) chk("glitch_reject", air_humidity, 1'b0);
         if (c == 28) chk("repeat_c28", pulse_2, REP_ON);
         run_cycle(d, 1'b1);
      end

      // Reset in the middle of a debounce discards the partial count.
      repeat (3) run_cycle(base, 1'b0);
      for (int c = 0; c < 10; c++) begin
         if (c == 9) chk("sel_pre_reset", selector, 1'b0);
         run_cycle(base | 9'b001000000, (c != 9));
      end
      for (int c = 0; c < 20; c++) begin
         if (c == 2 || c == 11) chk("sel_restart_low", selector, 1'b0);
         if (c == 12) chk("sel_restart_high", selector, 1'b1);
         run_cycle(base | 9'b001000000, 1'b1);
      end

      // Both buttons pressed together.
      repeat (2) run_cycle(base, 1'b0);
      for (int c = 0; c < 20; c++) begin
         if (c == 12) begin
            chk("dual_pulse_3", pulse_3, 1'b1);
            chk("dual_pulse_2", pulse_2, 1'b1);
         end
         run_cycle(9'b000000000, 1'b1);
      end

      // Random slow walks on every input with occasional resets.
      repeat (2) run_cycle(base, 1'b0);
      d = base;
      for (int c = 0; c < 700; c++) begin
         for (int b = 0; b < 9; b++)
            if ($urandom_range(15) == 0) d[b] = ~d[b];
         rst = ($urandom_range(249) != 0);
         run_cycle(d, rst);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
